// File: rtl/alu_rs.sv
// Four-entry compacting reservation station feeding a single-cycle ALU.
// Operands wait for CDB broadcasts; the oldest fully-ready entry issues each cycle.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       dispatch_valid_i,
    output logic                       dispatch_ready_o,
    input  logic [31:0]                dispatch_pc_i,
    input  logic [31:0]                dispatch_inst_i,
    input  logic [TAG_W-1:0]           dispatch_rd_tag_i,
    input  logic                       dispatch_rs1_ready_i,
    input  logic                       dispatch_rs2_ready_i,
    input  logic [TAG_W-1:0]           dispatch_rs1_tag_i,
    input  logic [TAG_W-1:0]           dispatch_rs2_tag_i,
    input  logic [31:0]                dispatch_rs1_value_i,
    input  logic [31:0]                dispatch_rs2_value_i,
    input  logic                       cdb_valid_i,
    input  logic [TAG_W-1:0]           cdb_tag_i,
    input  logic [31:0]                cdb_value_i,
    input  logic                       flush_i,
    output logic                       alu_request_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                rs1_value_o,
    output logic [31:0]                rs2_value_o,
    output logic [TAG_W-1:0]           rd_tag_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic             valid;
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic [TAG_W-1:0] rd_tag;
        logic             rs1_rdy;
        logic [TAG_W-1:0] rs1_tag;
        logic [31:0]      rs1_val;
        logic             rs2_rdy;
        logic [TAG_W-1:0] rs2_tag;
        logic [31:0]      rs2_val;
    } entry_t;

    entry_t          r_ent   [DEPTH];
    entry_t          w_wake  [DEPTH];
    entry_t          w_shift [DEPTH];
    entry_t          w_next  [DEPTH];
    entry_t          w_disp;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_sel;
    logic            w_issue;
    logic            w_accept;
    logic            r_req;
    logic [31:0]     r_pc, r_inst, r_rs1, r_rs2;
    logic [TAG_W-1:0] r_rd;

    function automatic entry_t wake(input entry_t e);
        entry_t o;
        o = e;
        if (cdb_valid_i && e.valid) begin
            if (!e.rs1_rdy && e.rs1_tag == cdb_tag_i) begin
                o.rs1_rdy = 1'b1;
                o.rs1_val = cdb_value_i;
            end
            if (!e.rs2_rdy && e.rs2_tag == cdb_tag_i) begin
                o.rs2_rdy = 1'b1;
                o.rs2_val = cdb_value_i;
            end
        end
        return o;
    endfunction

    assign dispatch_ready_o = (r_count < CW'(DEPTH));
    assign w_accept         = dispatch_valid_i && dispatch_ready_o;
    assign w_wr_idx         = r_count - CW'(w_issue);

    // The incoming entry goes through the same wakeup as stored ones (CDB bypass).
    always_comb begin
        w_disp = wake('{valid:   1'b1,
                        pc:      dispatch_pc_i,
                        inst:    dispatch_inst_i,
                        rd_tag:  dispatch_rd_tag_i,
                        rs1_rdy: dispatch_rs1_ready_i,
                        rs1_tag: dispatch_rs1_tag_i,
                        rs1_val: dispatch_rs1_value_i,
                        rs2_rdy: dispatch_rs2_ready_i,
                        rs2_tag: dispatch_rs2_tag_i,
                        rs2_val: dispatch_rs2_value_i});
    end

    always_comb begin
        w_issue = 1'b0;
        w_sel   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_ent[i].valid && r_ent[i].rs1_rdy && r_ent[i].rs2_rdy) begin
                w_issue = 1'b1;
                w_sel   = IW'(i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
            assign w_wake[gi] = wake(r_ent[gi]);
            if (gi < DEPTH - 1) begin : g_mid
                assign w_shift[gi] = (w_issue && gi >= int'(w_sel)) ? w_wake[gi+1] : w_wake[gi];
            end else begin : g_top
                assign w_shift[gi] = (w_issue && gi >= int'(w_sel)) ? entry_t'('0) : w_wake[gi];
            end
            assign w_next[gi] = (w_accept && w_wr_idx == CW'(gi)) ? w_disp : w_shift[gi];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= w_next[i];
            r_count <= r_count + CW'(w_accept) - CW'(w_issue);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_req  <= 1'b0;
            r_pc   <= '0;
            r_inst <= '0;
            r_rs1  <= '0;
            r_rs2  <= '0;
            r_rd   <= '0;
        end else if (flush_i) begin
            r_req <= 1'b0;
        end else begin
            r_req <= w_issue;
            if (w_issue) begin
                r_pc   <= r_ent[w_sel].pc;
                r_inst <= r_ent[w_sel].inst;
                r_rs1  <= r_ent[w_sel].rs1_val;
                r_rs2  <= r_ent[w_sel].rs2_val;
                r_rd   <= r_ent[w_sel].rd_tag;
            end
        end
    end

    assign alu_request_o = r_req;
    assign pc_o          = r_pc;
    assign inst_o        = r_inst;
    assign rs1_value_o   = r_rs1;
    assign rs2_value_o   = r_rs2;
    assign rd_tag_o      = r_rd;
    assign count_o       = r_count;

endmodule

// File: tb/tb_alu_rs.sv
// Bench for alu_rs: directed scenarios plus random traffic, checked against an
// age-ordered queue model of the station.
module tb_alu_rs;
    localparam int DEPTH = 4;
    localparam int TAG_W = 6;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        dispatch_valid_i;
    logic        dispatch_ready_o;
    logic [31:0] dispatch_pc_i, dispatch_inst_i;
    logic [5:0]  dispatch_rd_tag_i;
    logic        dispatch_rs1_ready_i, dispatch_rs2_ready_i;
    logic [5:0]  dispatch_rs1_tag_i, dispatch_rs2_tag_i;
    logic [31:0] dispatch_rs1_value_i, dispatch_rs2_value_i;
    logic        cdb_valid_i;
    logic [5:0]  cdb_tag_i;
    logic [31:0] cdb_value_i;
    logic        flush_i;
    logic        alu_request_o;
    logic [31:0] pc_o, inst_o, rs1_value_o, rs2_value_o;
    logic [5:0]  rd_tag_o;
    logic [2:0]  count_o;

    always #5 clk_i = ~clk_i;

    alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .dispatch_valid_i(dispatch_valid_i), .dispatch_ready_o(dispatch_ready_o),
        .dispatch_pc_i(dispatch_pc_i), .dispatch_inst_i(dispatch_inst_i),
        .dispatch_rd_tag_i(dispatch_rd_tag_i),
        .dispatch_rs1_ready_i(dispatch_rs1_ready_i), .dispatch_rs2_ready_i(dispatch_rs2_ready_i),
        .dispatch_rs1_tag_i(dispatch_rs1_tag_i), .dispatch_rs2_tag_i(dispatch_rs2_tag_i),
        .dispatch_rs1_value_i(dispatch_rs1_value_i), .dispatch_rs2_value_i(dispatch_rs2_value_i),
        .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_value_i(cdb_value_i),
        .flush_i(flush_i), .alu_request_o(alu_request_o),
        .pc_o(pc_o), .inst_o(inst_o), .rs1_value_o(rs1_value_o), .rs2_value_o(rs2_value_o),
        .rd_tag_o(rd_tag_o), .count_o(count_o)
    );

    typedef struct {
        logic [31:0] pc, inst;
        logic [5:0]  rd;
        logic        r1;
        logic [5:0]  t1;
        logic [31:0] v1;
        logic        r2;
        logic [5:0]  t2;
        logic [31:0] v2;
    } ent_t;

    ent_t        q[$];
    logic        e_req;
    logic [31:0] e_pc, e_inst, e_v1, e_v2;
    logic [5:0]  e_rd;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string ph);
        chk({ph, ".req"},   32'(alu_request_o), 32'(e_req));
        chk({ph, ".count"}, 32'(count_o),       32'(q.size()));
        chk({ph, ".pc"},    pc_o,               e_pc);
        chk({ph, ".inst"},  inst_o,             e_inst);
        chk({ph, ".rs1"},   rs1_value_o,        e_v1);
        chk({ph, ".rs2"},   rs2_value_o,        e_v2);
        chk({ph, ".rd"},    32'(rd_tag_o),      32'(e_rd));
    endtask

    task automatic model_reset();
        q.delete();
        e_req = 0; e_pc = 0; e_inst = 0; e_v1 = 0; e_v2 = 0; e_rd = 0;
    endtask

    // One clock edge: check ready, advance the model by the station's rules, compare.
    task automatic tick(input string ph);
        ent_t n;
        int   idx;
        logic acc;
        chk({ph, ".dready"}, 32'(dispatch_ready_o), 32'(q.size() < DEPTH));
        @(posedge clk_i);
        if (flush_i) begin
            q.delete();
            e_req = 0;
        end else begin
            acc = dispatch_valid_i && (q.size() < DEPTH);
            idx = -1;
            for (int i = 0; i < q.size(); i++)
                if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
            e_req = (idx >= 0);
            if (idx >= 0) begin
                e_pc = q[idx].pc; e_inst = q[idx].inst; e_rd = q[idx].rd;
                e_v1 = q[idx].v1; e_v2 = q[idx].v2;
                q.delete(idx);
            end
            if (acc) begin
                n.pc = dispatch_pc_i; n.inst = dispatch_inst_i; n.rd = dispatch_rd_tag_i;
                n.r1 = dispatch_rs1_ready_i; n.t1 = dispatch_rs1_tag_i; n.v1 = dispatch_rs1_value_i;
                n.r2 = dispatch_rs2_ready_i; n.t2 = dispatch_rs2_tag_i; n.v2 = dispatch_rs2_value_i;
                q.push_back(n);
            end
            if (cdb_valid_i) begin
                foreach (q[i]) begin
                    if (!q[i].r1 && q[i].t1 == cdb_tag_i) begin q[i].r1 = 1; q[i].v1 = cdb_value_i; end
                    if (!q[i].r2 && q[i].t2 == cdb_tag_i) begin q[i].r2 = 1; q[i].v2 = cdb_value_i; end
                end
            end
        end
        #1;
        compare_all(ph);
    endtask

    task automatic idle_in();
        dispatch_valid_i = 0;
        cdb_valid_i      = 0;
        flush_i          = 0;
    endtask

    task automatic set_disp(input logic [31:0] pc, input logic [31:0] inst, input logic [5:0] rd,
                            input logic r1, input logic [5:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [5:0] t2, input logic [31:0] v2);
        dispatch_valid_i = 1;
        dispatch_pc_i = pc; dispatch_inst_i = inst; dispatch_rd_tag_i = rd;
        dispatch_rs1_ready_i = r1; dispatch_rs1_tag_i = t1; dispatch_rs1_value_i = v1;
        dispatch_rs2_ready_i = r2; dispatch_rs2_tag_i = t2; dispatch_rs2_value_i = v2;
    endtask

    task automatic set_cdb(input logic [5:0] tag, input logic [31:0] val);
        cdb_valid_i = 1; cdb_tag_i = tag; cdb_value_i = val;
    endtask

    initial begin
        reset_i = 1;
        idle_in();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dispatch_valid_i = 0;
        cdb_tag_i = 0; cdb_value_i = 0;
        model_reset();
        #12;
        compare_all("reset");
        chk("reset.dready", 32'(dispatch_ready_o), 32'd1);
        reset_i = 0;

        // Fully-ready ADDI: request only after the second edge
        set_disp(32'h100, 32'h0050_0093, 6'd3, 1, 0, 32'd7, 1, 0, 32'd0);
        tick("t1.e1");
        idle_in();
        chk("t1.noreq", 32'(alu_request_o), 32'd0);
        tick("t1.e2");
        chk("t1.req", 32'(alu_request_o), 32'd1);
        chk("t1.pc", pc_o, 32'h100);
        chk("t1.rs1", rs1_value_o, 32'd7);
        tick("t1.e3");

        // ADD waiting on tag 5
        set_disp(32'h104, 32'h0020_81b3, 6'd8, 0, 6'd5, 32'd0, 1, 0, 32'd9);
        tick("t2.disp");
        idle_in();
        set_cdb(6'd6, 32'h1111_1111);
        tick("t2.cdb6");
        set_cdb(6'd5, 32'hDEAD_BEEF);
        tick("t2.cdb5");
        idle_in();
        tick("t2.iss");
        chk("t2.req", 32'(alu_request_o), 32'd1);
        chk("t2.rs1", rs1_value_o, 32'hDEAD_BEEF);
        chk("t2.rs2", rs2_value_o, 32'd9);
        tick("t2.idle");

        // Dispatch-time bypass from the CDB
        set_disp(32'h108, 32'h0000_0033, 6'd9, 0, 6'd12, 32'd0, 1, 0, 32'd1);
        set_cdb(6'd12, 32'h55);
        tick("t3.disp");
        idle_in();
        tick("t3.iss");
        chk("t3.req", 32'(alu_request_o), 32'd1);
        chk("t3.rs1", rs1_value_o, 32'h55);
        tick("t3.idle");

        // Fill to full, drop a fifth dispatch, then release all in age order
        for (int k = 0; k < 4; k++) begin
            set_disp(32'h200 + 32'(k * 4), 32'h33 + 32'(k), 6'(10 + k), 0, 6'd20, 0, 1, 0, 32'(k));
            tick("t4.fill");
        end
        chk("t4.full", 32'(dispatch_ready_o), 32'd0);
        set_disp(32'h2F0, 32'h33, 6'd15, 1, 0, 32'd1, 1, 0, 32'd2);
        tick("t4.drop");
        chk("t4.cnt", 32'(count_o), 32'd4);
        idle_in();
        set_cdb(6'd20, 32'hCAFE_0000);
        tick("t4.wake");
        idle_in();
        for (int k = 0; k < 4; k++) begin
            tick("t4.iss");
            chk("t4.seqreq", 32'(alu_request_o), 32'd1);
            chk("t4.seqpc", pc_o, 32'h200 + 32'(k * 4));
        end
        tick("t4.drain");
        chk("t4.empty", 32'(alu_request_o), 32'd0);

        // Flush with a simultaneous dispatch
        for (int k = 0; k < 3; k++) begin
            set_disp(32'h300 + 32'(k * 4), 32'h33, 6'd1, 0, 6'd30, 0, 1, 0, 0);
            tick("t5.fill");
        end
        set_disp(32'h3F0, 32'h33, 6'd2, 1, 0, 32'd1, 1, 0, 32'd1);
        flush_i = 1;
        tick("t5.flush");
        chk("t5.cnt", 32'(count_o), 32'd0);
        chk("t5.req", 32'(alu_request_o), 32'd0);
        idle_in();
        set_cdb(6'd30, 32'h77);
        tick("t5.cdb");
        idle_in();
        for (int k = 0; k < 3; k++) tick("t5.quiet");

        // Asynchronous reset between edges with an issue in flight
        for (int k = 0; k < 3; k++) begin
            set_disp(32'h400 + 32'(k * 4), 32'h13, 6'd4, 1, 0, 32'(k + 1), 1, 0, 32'd5);
            tick("t6.fill");
        end
        idle_in();
        chk("t6.pre", 32'(alu_request_o), 32'd1);
        #2 reset_i = 1;
        model_reset();
        #1;
        compare_all("t6.areset");
        chk("t6.dready", 32'(dispatch_ready_o), 32'd1);
        #1 reset_i = 0;
        for (int k = 0; k < 3; k++) tick("t6.quiet");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle_in();
            if ($urandom_range(2) != 0)
                set_disp($urandom, $urandom, 6'($urandom_range(63)),
                         1'($urandom_range(1)), 6'($urandom_range(7)), $urandom,
                         1'($urandom_range(1)), 6'($urandom_range(7)), $urandom);
            if ($urandom_range(1) != 0) set_cdb(6'($urandom_range(7)), $urandom);
            flush_i = ($urandom_range(39) == 0);
            tick("rnd");
        end
        idle_in();
        for (int k = 0; k < 6; k++) tick("rnd.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_rs.md
# alu_rs

Four-entry reservation station in front of the single-cycle arithmetic unit. It sits between rename/dispatch and the ALU. It accepts renamed integer instructions with operand values or producer tags, and captures missing operands by snooping the common data bus (CDB). Each cycle it issues the oldest fully-ready entry on the ALU request interface: request, PC, instruction, rs1 value, rs2 value and destination tag.

## Interface
- DEPTH, 4: number of entries (2..8)
- TAG_W, 6: physical tag width
- clk_i  in  1  clock; all state changes on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- dispatch_valid_i  in  1  dispatch request
- dispatch_ready_o  out  1  station can accept this cycle
- dispatch_pc_i, dispatch_inst_i  in  32 each  instruction PC and encoding
- dispatch_rd_tag_i  in  TAG_W  destination tag
- dispatch_rs1_ready_i, dispatch_rs2_ready_i  in  1 each  operand value already valid
- dispatch_rs1_tag_i, dispatch_rs2_tag_i  in  TAG_W each  producer tag, used when not ready
- dispatch_rs1_value_i, dispatch_rs2_value_i  in  32 each  operand value, used when ready
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  broadcast tag
- cdb_value_i  in  32  broadcast value
- flush_i  in  1  discard all entries (mispredict)
- alu_request_o  out  1  issue strobe to the ALU, one cycle per instruction
- pc_o, inst_o, rs1_value_o, rs2_value_o  out  32 each  issued operands
- rd_tag_o  out  TAG_W  issued destination tag
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is a compacting queue. Entry 0 is the oldest. Each entry holds: valid, pc, inst, rd_tag, and per operand {ready, tag, value}.
- Select: the lowest-index valid entry whose rs1 and rs2 ready bits are both registered high. Selection uses registered state only.
- Issue: the selected entry's fields load into the output registers and alu_request_o is set for one cycle. Higher entries shift down by one at the same edge. If nothing is selected, alu_request_o is 0 and the other outputs hold their last values.
- Dispatch: accepted when dispatch_valid_i && dispatch_ready_o. The entry is written at index count_o, or count_o-1 when an issue happens at the same edge.
- dispatch_ready_o = (count_o < DEPTH). It is combinational from count and does not credit a same-cycle issue.
- Wakeup: each valid entry operand with ready=0 and tag==cdb_tag_i while cdb_valid_i is high captures cdb_value_i and sets ready at the edge. Wakeup also applies to the entry as it shifts.
- Dispatch bypass: a dispatched operand with ready=0 whose tag matches a valid CDB broadcast in the same cycle is written as ready with cdb_value_i.
- Operands not used by the instruction (LUI, JAL immediates) are dispatched with ready=1. The station does not decode inst.
- Flush: at the edge, all valid bits are cleared, count becomes 0 and alu_request_o becomes 0. Flush has priority over dispatch and issue in the same cycle.
- count_o next = count + accept - issue, computed with flush taken into account.

## Timing
- Reset (asynchronous): all valid bits 0, count_o=0, alu_request_o=0, pc_o/inst_o/rs1_value_o/rs2_value_o/rd_tag_o=0. As a result dispatch_ready_o=1.
- Reset mid-operation discards all entries and any pending issue immediately, without waiting for a clock edge.
- Dispatch of a fully-ready instruction at edge E gives alu_request_o high in the cycle after edge E+1. Minimum latency is 2 edges.
- A wakeup captured at edge W makes the entry eligible for issue at edge W+1. alu_request_o is then high after W+1.
- Throughput is one issue per cycle. Back-to-back ready entries issue on consecutive cycles in age order.
- Full (count=DEPTH): dispatch_valid_i is ignored and no entry is written. Issue at the same edge does not admit a dispatch.
- Empty: alu_request_o=0 and the output data holds its last value.

## Test plan
- Reset, then dispatch ADDI (pc 0x100, inst 0x00500093, rs1 ready value 7, rs2 ready 0, rd_tag 3) at edge 1. Required: alu_request_o=1 only after edge 2, with pc_o=0x100, inst_o=0x00500093, rs1_value_o=7, rd_tag_o=3, count_o back to 0.
- Dispatch ADD with rs1 not ready (tag 5) and rs2 ready (9). Broadcast CDB tag 6 (no effect), then tag 5 with value 0xDEADBEEF at edge W. Required: issue one edge later with rs1_value_o=0xDEADBEEF and rs2_value_o=9.
- Dispatch rs1 tag 12 not ready while CDB broadcasts tag 12 value 0x55 in the same cycle. Required: issue 2 edges later with rs1_value_o=0x55.
- Fill 4 entries, each waiting on tag 20. Required: dispatch_ready_o=0 and a 5th dispatch is dropped (count_o stays 4). CDB tag 20 then wakes all four, which issue on 4 consecutive cycles in dispatch order (check the pc_o sequence).
- With 3 waiting entries, assert flush_i together with a dispatch. Required: count_o=0 and alu_request_o=0 next cycle, and no later issue. Repeat with an asynchronous reset_i pulse between edges; outputs must clear immediately.
